ball_renderer: RTL and testbench
================================

Name: ball_renderer

Overview:
Pixel-generation stage directly downstream of video_sync_generator. It consumes hpos/vpos/visible/hsync/vsync and moves a square ball once per frame, bouncing it off the visible-area edges. It outputs an RGB pixel plus hsync/vsync, all re-registered so they stay aligned, for the board's VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
BALL_SIZE, 8, ball edge length in pixels (1..min(H_VISIBLE,V_VISIBLE))
H_SPEED, 2, horizontal pixels moved per frame (>=1, < H_VISIBLE-BALL_SIZE)
V_SPEED, 2, vertical pixels moved per frame (>=1, < V_VISIBLE-BALL_SIZE)
X_START, 0, ball left edge after reset
Y_START, 0, ball top edge after reset
BALL_COLOR, 9'h1FF, RGB333 ball colour
BG_COLOR, 9'h007, RGB333 background colour inside visible area

Ports:
i_clk  input  1  pixel clock
i_rst  input  1  synchronous reset, active-high
i_run  input  1  1 = ball moves at each frame tick; 0 = ball frozen
i_hsync  input  1  hsync from sync generator (active-high)
i_vsync  input  1  vsync from sync generator (active-high)
i_visible  input  1  high when hpos/vpos are inside the visible area
i_hpos  input  10  current column
i_vpos  input  10  current row
o_hsync  output  1  i_hsync delayed 1 cycle
o_vsync  output  1  i_vsync delayed 1 cycle
o_rgb  output  9  {R[2:0],G[2:0],B[2:0]} pixel, registered
o_ball_x  output  10  current ball left edge (debug/test)
o_ball_y  output  10  current ball top edge (debug/test)

Behaviour:
- One clock (i_clk); reset synchronous, active-high (i_rst).
- Reset: o_hsync=0, o_vsync=0, o_rgb=0, ball_x=X_START, ball_y=Y_START, dir_x=+1 (right), dir_y=+1 (down), vsync_prev=1.
- vsync_prev resets to 1, so no frame tick is produced if reset releases mid-vsync.
- Frame tick: asserted for one cycle when i_vsync=1 and vsync_prev=0. vsync_prev<=i_vsync every cycle.
- Motion on tick with i_run=1. Horizontal; vertical is identical with y/V_*.
  - Moving right: if ball_x + H_SPEED >= H_VISIBLE-BALL_SIZE, set ball_x=H_VISIBLE-BALL_SIZE and dir_x=left. Otherwise ball_x += H_SPEED.
  - Moving left: if ball_x <= H_SPEED, set ball_x=0 and dir_x=right. Otherwise ball_x -= H_SPEED.
  - Compute in 11 bits; no wrap-around permitted.
- Tick with i_run=0: position and direction unchanged.
- i_run changes take effect at the next tick only.
- Pixel (latency 1):
  - ball_on = i_visible & (i_hpos>=ball_x) & (i_hpos<ball_x+BALL_SIZE) & (i_vpos>=ball_y) & (i_vpos<ball_y+BALL_SIZE).
  - o_rgb <= ball_on ? BALL_COLOR : (i_visible ? BG_COLOR : 0).
  - o_hsync <= i_hsync; o_vsync <= i_vsync.
- Same-cycle tick and pixel compare: the compare uses pre-update position. The new position is used from the next cycle. The tick always falls in vblank, so no tearing.
- Reset asserted mid-frame: all state returns to reset values on that edge. o_rgb=0 while i_rst=1.

Decomposition:
- Shared package video_pkg: typedef rgb333_t (9 bits), typedef pos_t (10 bits), constants COLOR_BLACK/COLOR_WHITE, and 640x480 timing constants shared with the sync generator.
- One sub-module, rising_edge_detect: 1-bit input, reset value parameter, one-cycle pulse output. Used for the frame tick.
- Per-axis bounce logic is duplicated inline; no sub-module.

Test Plan:
- Bench config: H_VISIBLE=10, V_VISIBLE=3, BALL_SIZE=2, H_SPEED=1, V_SPEED=1, X_START=0, Y_START=0, driven by video_sync_generator with the 10x3 timing.
- Reset then first visible pixel: hpos=0,vpos=0 -> o_rgb=BALL_COLOR one cycle later. hpos=2 -> BG_COLOR. A blanking cycle -> 0.
- i_run=1, count vsync rising edges: ball_x goes 0,1,2,...,8 then 7 (bounce at H_VISIBLE-BALL_SIZE=8). ball_y goes 0,1,0,1 (bounce at 1 and 0).
- i_run=0 across 3 frames -> ball_x/ball_y unchanged. i_run=1 -> motion resumes with direction preserved.
- Reset asserted while i_vsync=1 and released mid-vsync -> no tick that frame; ball_x stays 0 until the next vsync rising edge.
- Sync alignment: o_hsync/o_vsync equal i_hsync/i_vsync delayed exactly 1 cycle over a full frame. o_rgb is nonzero only where i_visible was 1 one cycle earlier.
- Edge config: X_START=8, dir right, H_SPEED=1 -> first tick clamps ball_x=8 and reverses. Second tick ball_x=7.

Source files
------------

// File: rtl/video_pkg.sv
// ============================================================================
// video_pkg : pixel/position types, colours and 640x480 VGA timing constants
// Rev 1.0
// ============================================================================
`default_nettype none

package video_pkg;

   typedef logic [8:0] rgb333_t;
   typedef logic [9:0] pos_t;

   typedef enum logic {
      DIR_NEG = 1'b0,
      DIR_POS = 1'b1
   } dir_t;

   localparam rgb333_t COLOR_BLACK = 9'h000;
   localparam rgb333_t COLOR_WHITE = 9'h1FF;

   localparam int c_h_visible = 640;
   localparam int c_h_front   = 16;
   localparam int c_h_sync    = 96;
   localparam int c_h_back    = 48;
   localparam int c_v_visible = 480;
   localparam int c_v_front   = 10;
   localparam int c_v_sync    = 2;
   localparam int c_v_back    = 33;

endpackage

`default_nettype wire

// File: rtl/rising_edge_detect.sv
// ============================================================================
// rising_edge_detect : one-cycle pulse on a 0->1 transition of i_d
// Rev 1.0
// ============================================================================
`default_nettype none

module rising_edge_detect #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_pulse
);

   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= RESET_VALUE;
      end else begin
         r_prev <= i_d;
      end
   end

   assign o_pulse = i_d & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/ball_renderer.sv
// ============================================================================
// ball_renderer : bouncing square ball drawn over the sync generator's raster
// Rev 1.0
// ============================================================================
`default_nettype none

module ball_renderer
   import video_pkg::*;
#(
   parameter int      H_VISIBLE  = c_h_visible,
   parameter int      V_VISIBLE  = c_v_visible,
   parameter int      BALL_SIZE  = 8,
   parameter int      H_SPEED    = 2,
   parameter int      V_SPEED    = 2,
   parameter int      X_START    = 0,
   parameter int      Y_START    = 0,
   parameter rgb333_t BALL_COLOR = 9'h1FF,
   parameter rgb333_t BG_COLOR   = 9'h007
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_run,
   input  logic       i_hsync,
   input  logic       i_vsync,
   input  logic       i_visible,
   input  logic [9:0] i_hpos,
   input  logic [9:0] i_vpos,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic [8:0] o_rgb,
   output logic [9:0] o_ball_x,
   output logic [9:0] o_ball_y
);

   localparam logic [10:0] c_x_max   = 11'(H_VISIBLE - BALL_SIZE);
   localparam logic [10:0] c_y_max   = 11'(V_VISIBLE - BALL_SIZE);
   localparam logic [10:0] c_h_speed = 11'(H_SPEED);
   localparam logic [10:0] c_v_speed = 11'(V_SPEED);
   localparam logic [10:0] c_size    = 11'(BALL_SIZE);

   pos_t    r_ball_x;
   pos_t    r_ball_y;
   dir_t    r_dir_x;
   dir_t    r_dir_y;
   logic    r_hsync;
   logic    r_vsync;
   rgb333_t r_rgb;

   logic    w_tick;
   pos_t    w_next_x;
   pos_t    w_next_y;
   dir_t    w_next_dir_x;
   dir_t    w_next_dir_y;
   logic    w_ball_on;

   rising_edge_detect #(
      .RESET_VALUE (1'b1)
   ) u_frame_tick (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_d     (i_vsync),
      .o_pulse (w_tick)
   );

   // Sums are widened to 11 bits so the bounce tests can never wrap.
   logic [10:0] w_x_ext;
   logic [10:0] w_y_ext;
   assign w_x_ext = {1'b0, r_ball_x};
   assign w_y_ext = {1'b0, r_ball_y};

   always_comb begin
      w_next_x     = r_ball_x;
      w_next_dir_x = r_dir_x;
      if (r_dir_x == DIR_POS) begin
         if (w_x_ext + c_h_speed >= c_x_max) begin
            w_next_x     = c_x_max[9:0];
            w_next_dir_x = DIR_NEG;
         end else begin
            w_next_x = 10'(w_x_ext + c_h_speed);
         end
      end else begin
         if (w_x_ext <= c_h_speed) begin
            w_next_x     = '0;
            w_next_dir_x = DIR_POS;
         end else begin
            w_next_x = 10'(w_x_ext - c_h_speed);
         end
      end
   end

   always_comb begin
      w_next_y     = r_ball_y;
      w_next_dir_y = r_dir_y;
      if (r_dir_y == DIR_POS) begin
         if (w_y_ext + c_v_speed >= c_y_max) begin
            w_next_y     = c_y_max[9:0];
            w_next_dir_y = DIR_NEG;
         end else begin
            w_next_y = 10'(w_y_ext + c_v_speed);
         end
      end else begin
         if (w_y_ext <= c_v_speed) begin
            w_next_y     = '0;
            w_next_dir_y = DIR_POS;
         end else begin
            w_next_y = 10'(w_y_ext - c_v_speed);
         end
      end
   end

   // Compare against the current (pre-update) position; a same-cycle tick
   // only becomes visible from the next pixel on.
   assign w_ball_on = i_visible
                    & ({1'b0, i_hpos} >= w_x_ext)
                    & ({1'b0, i_hpos} <  w_x_ext + c_size)
                    & ({1'b0, i_vpos} >= w_y_ext)
                    & ({1'b0, i_vpos} <  w_y_ext + c_size);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ball_x <= 10'(X_START);
         r_ball_y <= 10'(Y_START);
         r_dir_x  <= DIR_POS;
         r_dir_y  <= DIR_POS;
         r_hsync  <= 1'b0;
         r_vsync  <= 1'b0;
         r_rgb    <= COLOR_BLACK;
      end else begin
         r_hsync <= i_hsync;
         r_vsync <= i_vsync;
         if (w_ball_on) begin
            r_rgb <= BALL_COLOR;
         end else if (i_visible) begin
            r_rgb <= BG_COLOR;
         end else begin
            r_rgb <= COLOR_BLACK;
         end
         if (w_tick && i_run) begin
            r_ball_x <= w_next_x;
            r_ball_y <= w_next_y;
            r_dir_x  <= w_next_dir_x;
            r_dir_y  <= w_next_dir_y;
         end
      end
   end

   assign o_hsync  = r_hsync;
   assign o_vsync  = r_vsync;
   assign o_rgb    = r_rgb;
   assign o_ball_x = r_ball_x;
   assign o_ball_y = r_ball_y;

endmodule

`default_nettype wire

// File: tb/tb_ball_renderer.sv
// ============================================================================
// tb_ball_renderer : scoreboard bench on a 10x3 raster for ball_renderer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ball_renderer;

   localparam int HV = 10;
   localparam int VV = 3;
   localparam int BS = 2;
   localparam int HS = 1;
   localparam int VS = 1;
   localparam int H_TOTAL = 14;
   localparam int V_TOTAL = 6;
   localparam logic [8:0] BALL = 9'h1FF;
   localparam logic [8:0] BG   = 9'h007;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       hsync = 1'b0;
   logic       vsync = 1'b0;
   logic       visible = 1'b0;
   logic [9:0] hpos = '0;
   logic [9:0] vpos = '0;

   logic       o_hsync, o_vsync;
   logic [8:0] o_rgb;
   logic [9:0] o_ball_x, o_ball_y;

   logic       e_hsync, e_vsync;
   logic [8:0] e_rgb;
   logic [9:0] e_ball_x, e_ball_y;

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] exp_q[$];

   int  m_x, m_y;
   bit  m_dx, m_dy, m_prev;

   always #5 clk = ~clk;

   ball_renderer #(
      .H_VISIBLE (HV), .V_VISIBLE (VV), .BALL_SIZE (BS),
      .H_SPEED (HS), .V_SPEED (VS), .X_START (0), .Y_START (0),
      .BALL_COLOR (BALL), .BG_COLOR (BG)
   ) dut (
      .i_clk (clk), .i_rst (rst), .i_run (run),
      .i_hsync (hsync), .i_vsync (vsync), .i_visible (visible),
      .i_hpos (hpos), .i_vpos (vpos),
      .o_hsync (o_hsync), .o_vsync (o_vsync), .o_rgb (o_rgb),
      .o_ball_x (o_ball_x), .o_ball_y (o_ball_y)
   );

   ball_renderer #(
      .H_VISIBLE (HV), .V_VISIBLE (VV), .BALL_SIZE (BS),
      .H_SPEED (HS), .V_SPEED (VS), .X_START (8), .Y_START (0),
      .BALL_COLOR (BALL), .BG_COLOR (BG)
   ) dut_edge (
      .i_clk (clk), .i_rst (rst), .i_run (run),
      .i_hsync (hsync), .i_vsync (vsync), .i_visible (visible),
      .i_hpos (hpos), .i_vpos (vpos),
      .o_hsync (e_hsync), .o_vsync (e_vsync), .o_rgb (e_rgb),
      .o_ball_x (e_ball_x), .o_ball_y (e_ball_y)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_prev = 1;
   endtask

   task automatic model_move();
      if (m_dx) begin
         if (m_x + HS >= HV - BS) begin m_x = HV - BS; m_dx = 0; end
         else m_x = m_x + HS;
      end else begin
         if (m_x <= HS) begin m_x = 0; m_dx = 1; end
         else m_x = m_x - HS;
      end
      if (m_dy) begin
         if (m_y + VS >= VV - BS) begin m_y = VV - BS; m_dy = 0; end
         else m_y = m_y + VS;
      end else begin
         if (m_y <= VS) begin m_y = 0; m_dy = 1; end
         else m_y = m_y - VS;
      end
   endtask

   // One pixel clock: drive, predict, then compare what the DUT produced.
   task automatic drive_cycle(input bit r, input bit hs, input bit vs, input bit vis,
                              input int h, input int v);
      logic [8:0]  e_rgb_v;
      logic [10:0] got;
      bit          on;
      rst = r; hsync = hs; vsync = vs; visible = vis;
      hpos = 10'(h); vpos = 10'(v);
      if (r) begin
         exp_q.push_back(11'h0);
         model_reset();
      end else begin
         on = vis && (h >= m_x) && (h < m_x + BS) && (v >= m_y) && (v < m_y + BS);
         e_rgb_v = on ? BALL : (vis ? BG : 9'h000);
         exp_q.push_back({e_rgb_v, hs, vs});
         if (vs && !m_prev && run) model_move();
         m_prev = vs;
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 32'd1, 32'd0);
      end else begin
         got = exp_q.pop_front();
         check_eq("rgb",   32'(o_rgb),   32'(got[10:2]));
         check_eq("hsync", 32'(o_hsync), 32'(got[1]));
         check_eq("vsync", 32'(o_vsync), 32'(got[0]));
      end
      check_eq("ball_x", 32'(o_ball_x), 32'(m_x));
      check_eq("ball_y", 32'(o_ball_y), 32'(m_y));
   endtask

   // Full frame; rst is held high on line rst_v for columns [rst_h0, rst_h1).
   task automatic run_frame(input int rst_v, input int rst_h0, input int rst_h1);
      for (int v = 0; v < V_TOTAL; v++) begin
         for (int h = 0; h < H_TOTAL; h++) begin
            drive_cycle((v == rst_v) && (h >= rst_h0) && (h < rst_h1),
                        (h == 11) || (h == 12), v == 4,
                        (h < HV) && (v < VV), h, v);
         end
      end
   endtask

   int exp_x[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 7};
   int exp_y[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};

   initial begin
      model_reset();
      run = 1'b1;
      for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1, 0, 0, 5);
      check_eq("reset_x", 32'(o_ball_x), 32'd0);
      check_eq("reset_rgb", 32'(o_rgb), 32'd0);

      for (int k = 0; k < 9; k++) begin
         run_frame(-1, 0, 0);
         check_eq("tick_x", 32'(o_ball_x), 32'(exp_x[k]));
         check_eq("tick_y", 32'(o_ball_y), 32'(exp_y[k]));
         if (k == 0) check_eq("edge_x1", 32'(e_ball_x), 32'd8);
         if (k == 1) check_eq("edge_x2", 32'(e_ball_x), 32'd7);
      end

      run = 1'b0;
      for (int k = 0; k < 3; k++) run_frame(-1, 0, 0);
      check_eq("frozen_x", 32'(o_ball_x), 32'd7);
      check_eq("frozen_y", 32'(o_ball_y), 32'd1);

      run = 1'b1;
      run_frame(-1, 0, 0);
      check_eq("resume_x", 32'(o_ball_x), 32'd6);
      check_eq("resume_y", 32'(o_ball_y), 32'd0);

      run_frame(4, 2, 5);
      check_eq("vsync_rst_x", 32'(o_ball_x), 32'd0);
      check_eq("vsync_rst_y", 32'(o_ball_y), 32'd0);
      run_frame(-1, 0, 0);
      check_eq("after_rst_x", 32'(o_ball_x), 32'd1);
      check_eq("after_rst_y", 32'(o_ball_y), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
